// File: rtl/pc_sequencer_if.sv
// Control strobes from decode into the PC sequencer, and the fetch address / stack status it returns.
interface pc_sequencer_if;
  logic       stall;
  logic       branch_en;
  logic [7:0] branch_target;
  logic       call_en;
  logic [7:0] call_target;
  logic       ret_en;
  logic       halt_en;
  logic [7:0] pcAddress;
  logic [3:0] stack_count;
  logic       stack_overflow;
  logic       stack_underflow;
  logic       halted;

  modport master (
    output stall, branch_en, branch_target, call_en, call_target, ret_en, halt_en,
    input  pcAddress, stack_count, stack_overflow, stack_underflow, halted
  );

  modport slave (
    input  stall, branch_en, branch_target, call_en, call_target, ret_en, halt_en,
    output pcAddress, stack_count, stack_overflow, stack_underflow, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer for a byte-addressed, 16-bit instruction memory: fetch, stall,
// branch, call/return through a small LIFO of return addresses, and halt.
module pc_sequencer #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [7:0] RESET_PC    = 8'h00
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t           state, state_nxt;
  logic [7:0]       pc, pc_nxt, pc_inc;
  logic [3:0]       count, count_nxt;
  logic             ovf, ovf_nxt;
  logic             unf, unf_nxt;
  logic             push;
  logic             full, empty;
  logic [PTR_W-1:0] push_idx, top_idx;
  logic [7:0]       stack_mem [STACK_DEPTH];

  assign pc_inc   = pc + 8'd2;
  assign full     = (count == 4'(STACK_DEPTH));
  assign empty    = (count == 4'd0);
  // The entry count doubles as the stack pointer: next free slot is count, top is count-1.
  assign push_idx = count[PTR_W-1:0];
  assign top_idx  = push_idx - PTR_W'(1);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = count;
    ovf_nxt   = ovf;
    unf_nxt   = unf;
    push      = 1'b0;
    if (state == S_HALT || bus.stall) begin
      // everything holds; strobes are dropped
    end else if (bus.halt_en) begin
      state_nxt = S_HALT;
    end else if (bus.ret_en) begin
      if (!empty) begin
        pc_nxt    = stack_mem[top_idx];
        count_nxt = count - 4'd1;
      end else begin
        unf_nxt = 1'b1;
        pc_nxt  = pc_inc;
      end
    end else if (bus.call_en) begin
      if (!full) begin
        push      = 1'b1;
        count_nxt = count + 4'd1;
        pc_nxt    = bus.call_target & 8'hFE;
      end else begin
        ovf_nxt = 1'b1;
        pc_nxt  = pc_inc;
      end
    end else if (bus.branch_en) begin
      pc_nxt = bus.branch_target & 8'hFE;
    end else begin
      pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      count <= 4'd0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end

  // Stack contents are data only; a stray write during reset is harmless.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= pc_inc;
  end

  assign bus.pcAddress       = pc;
  assign bus.stack_count     = count;
  assign bus.stack_overflow  = ovf;
  assign bus.stack_underflow = unf;
  assign bus.halted          = (state == S_HALT);

endmodule
